phys_reg_file: RTL and testbench
================================

Name: phys_reg_file

Overview:
Parametrised physical register file for the out-of-order core: a bank of NUM_REGS enable registers, each WIDTH bits wide, plus a per-register ready bit.
- Ports: NUM_RD combinational read ports, one write-back port (sets ready), one allocate port (clears ready).
- Write-to-read bypass is built in.
- An optional hardwired zero register is supported.
- Sits between rename (allocate), issue (ready poll, operand read) and write-back.

Parameters:
WIDTH, 64, data bits per register
NUM_REGS, 64, number of physical registers (power of 2, ≥4)
NUM_RD, 2, number of read ports
ZERO_EN, 1, 1 = register ZERO_IDX is hardwired zero
ZERO_IDX, NUM_REGS-1, index of the zero register
AW, $clog2(NUM_REGS), address width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
wr_en  input  1  write-back enable
wr_addr  input  AW  write-back index
wr_data  input  WIDTH  write-back data
alloc_en  input  1  allocate: clear ready of alloc_addr
alloc_addr  input  AW  register being allocated
rd_addr  input  NUM_RD*AW  read indices, port p at [p*AW +: AW]
rd_data  output  NUM_RD*WIDTH  read data, port p at [p*WIDTH +: WIDTH]
rd_ready  output  NUM_RD  ready bit of each read index (bypassed)
all_ready  output  NUM_REGS  raw registered ready vector (no bypass)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - reset sampled high at a posedge: all data registers ← 0, all ready bits ← 1.
  - Reset overrides wr_en and alloc_en in that cycle.
  - Reset mid-operation discards any in-flight write or alloc.
- After reset, before any write:
  - every rd_data = 0, every rd_ready = 1;
  - all_ready = all ones.
- Write (posedge, wr_en=1, reset=0):
  - reg[wr_addr] ← wr_data;
  - ready[wr_addr] ← 1;
  - other registers hold (per-register enable = wr_en & decode).
- Allocate (posedge, alloc_en=1, reset=0): ready[alloc_addr] ← 0; data unchanged.
- Simultaneous write and alloc to the same index: data written, ready ← 0 (alloc wins on ready). Different indices: both take effect.
- Read: combinational, zero-latency.
  - If wr_en && wr_addr==rd_addr[p] and the index is not the zero register: rd_data[p] = wr_data and rd_ready[p] = 1 (bypass).
  - Else rd_data[p] = reg[rd_addr[p]] and rd_ready[p] = ready[rd_addr[p]].
  - The bypass ignores a same-cycle alloc, because alloc only affects the next cycle.
- Zero register (ZERO_EN=1):
  - reads of ZERO_IDX return 0 and ready 1 on every port;
  - writes and allocs to it are ignored; it is never bypassed;
  - its all_ready bit is constant 1.
- Multiple read ports may address the same index; each returns identical values.
- all_ready reflects only registered state; it is not bypassed.
- Addresses ≥ NUM_REGS cannot occur (NUM_REGS is a power of 2).

Decomposition:
- Package phys_reg_file_pkg holds:
  - default WIDTH, NUM_REGS, NUM_RD, ZERO_IDX;
  - the derived AW;
  - typedef preg_idx_t (logic [AW-1:0]);
  - typedef preg_data_t (logic [WIDTH-1:0]).
- Natural sub-module en_reg_n: WIDTH-parameterised enable register with synchronous reset to 0.
  - Instantiated NUM_REGS times via generate.
  - The ready bits are a separate 1-bit vector with their own set/clear logic.
- Read muxes and the bypass comparator live in a per-port generate loop in the top module.

Test Plan:
1. Reset held 2 cycles, then rd_addr={5,9} → rd_data={0,0}, rd_ready=2'b11, all_ready all ones.
2. Write wr_addr=5, wr_data=64'h1F with rd_addr[0]=5 in the same cycle → rd_data[0]=64'h1F combinationally (bypass). Next cycle with wr_en=0 → still 64'h1F, ready 1.
3. alloc_addr=9 → next cycle rd_ready[1]=0 and all_ready[9]=0. Write 9 with 64'hDEAD_BEEF → bypassed ready 1 that cycle; registered ready 1 next cycle.
4. Same-cycle wr_en=1 and alloc_en=1, both to index 12, data 64'hAA → next cycle reg[12]=64'hAA, ready[12]=0. Separately, write 3 and alloc 4 together → both effects seen.
5. Write 64'hFFFF to ZERO_IDX (63) and alloc 63; read 63 on both ports → rd_data=0 and rd_ready=1 in the same cycle and after.
6. Write regs 1..4, assert reset in the middle of a write to reg 7 → next cycle all registers 0, all ready 1, reg 7 not written.

Source files
------------

// File: rtl/phys_reg_file_pkg.sv
// Purpose: shared defaults and index/data types for the physical register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package phys_reg_file_pkg;

    localparam int DEF_WIDTH    = 64;
    localparam int DEF_NUM_REGS = 64;
    localparam int DEF_NUM_RD   = 2;
    localparam int DEF_ZERO_EN  = 1;
    localparam int DEF_ZERO_IDX = DEF_NUM_REGS - 1;
    localparam int DEF_AW       = $clog2(DEF_NUM_REGS);

    typedef logic [DEF_AW-1:0]    preg_idx_t;
    typedef logic [DEF_WIDTH-1:0] preg_data_t;

endpackage

// File: rtl/phys_reg_file_en_reg_n.sv
// Purpose: WIDTH-bit enable register with synchronous clear, one per physical register.
// Latency: one cycle from en/d to q.
// Backpressure: none; en is sampled every cycle.
module en_reg_n #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Hold unless enabled; reset clears to zero and overrides the enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/phys_reg_file.sv
// Purpose: physical register file with per-register ready bits, write bypass and optional zero register.
// Latency: reads are combinational; write/alloc update state at the next rising edge.
// Backpressure: none; every write and alloc is accepted in the cycle it is presented.
module phys_reg_file
    import phys_reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_EN  = DEF_ZERO_EN,
    parameter int ZERO_IDX = NUM_REGS - 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     alloc_en,
    input  logic [AW-1:0]            alloc_addr,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WIDTH-1:0]  rd_data,
    output logic [NUM_RD-1:0]        rd_ready,
    output logic [NUM_REGS-1:0]      all_ready
);

    localparam logic [AW-1:0] ZIDX = AW'(ZERO_IDX);

    logic [WIDTH-1:0]    regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] ready_q;

    // Data bank: the zero register never gets a write enable, so it stays at its reset value.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam bit IS_ZERO = (ZERO_EN != 0) && (i == ZERO_IDX);
        logic en;
        assign en = wr_en && (wr_addr == AW'(i)) && !IS_ZERO;

        en_reg_n #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (en),
            .d     (wr_data),
            .q     (regs_q[i])
        );
    end

    // Ready bits: write sets, alloc clears afterwards so alloc wins on a same-index collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= '1;
        end else begin
            if (wr_en) begin
                ready_q[wr_addr] <= 1'b1;
            end
            if (alloc_en) begin
                ready_q[alloc_addr] <= 1'b0;
            end
            if (ZERO_EN != 0) begin
                ready_q[ZERO_IDX] <= 1'b1;
            end
        end
    end

    // Raw registered view for the scheduler; the zero bit is pinned high regardless of state.
    always_comb begin
        all_ready = ready_q;
        if (ZERO_EN != 0) begin
            all_ready[ZERO_IDX] = 1'b1;
        end
    end

    // Per-port read mux with write-back bypass; zero register takes priority over the bypass.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
        logic             rdy;
        logic             is_zero;

        assign addr    = rd_addr[p*AW +: AW];
        assign is_zero = (ZERO_EN != 0) && (addr == ZIDX);

        // Select zero, bypassed write data, or registered contents for this port.
        always_comb begin
            data = regs_q[addr];
            rdy  = ready_q[addr];
            if (is_zero) begin
                data = '0;
                rdy  = 1'b1;
            end else if (wr_en && (wr_addr == addr)) begin
                data = wr_data;
                rdy  = 1'b1;
            end
        end

        assign rd_data[p*WIDTH +: WIDTH] = data;
        assign rd_ready[p]               = rdy;
    end

endmodule

// File: tb/tb_phys_reg_file.sv
module tb_phys_reg_file;

    localparam int W  = 64;
    localparam int N  = 64;
    localparam int NR = 2;
    localparam int AW = 6;

    logic              clk;
    logic              reset;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [W-1:0]      wr_data;
    logic              alloc_en;
    logic [AW-1:0]     alloc_addr;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_ready;
    logic [N-1:0]      all_ready;

    int passed = 0;
    int total  = 0;

    phys_reg_file dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .all_ready  (all_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge, landing 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        alloc_en = 1'b0; alloc_addr = '0; rd_addr = '0;

        // 1. reset for two cycles
        step(); step();
        reset = 1'b0;
        set_rd(6'd5, 6'd9);
        #1;
        check("reset_rd_data", rd_data, 128'h0);
        check("reset_rd_ready", rd_ready, 2'b11);
        check("reset_all_ready", all_ready, {64{1'b1}});

        // 2. write 5 with bypass, then registered
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 64'h1F;
        #1;
        check("bypass_data5", rd_data[63:0], 64'h1F);
        step();
        wr_en = 1'b0;
        #1;
        check("reg_data5", rd_data[63:0], 64'h1F);
        check("reg_ready5", rd_ready, 2'b11);

        // 3. alloc 9, then write 9
        alloc_en = 1'b1; alloc_addr = 6'd9;
        step();
        alloc_en = 1'b0;
        #1;
        check("alloc9_rd_ready1", rd_ready[1], 1'b0);
        check("alloc9_all_ready", all_ready[9], 1'b0);
        wr_en = 1'b1; wr_addr = 6'd9; wr_data = 64'hDEAD_BEEF;
        #1;
        check("wr9_bypass_ready", rd_ready[1], 1'b1);
        check("wr9_bypass_data", rd_data[127:64], 64'hDEAD_BEEF);
        check("wr9_all_ready_unbypassed", all_ready[9], 1'b0);
        step();
        wr_en = 1'b0;
        #1;
        check("wr9_all_ready_next", all_ready[9], 1'b1);
        check("wr9_reg_data", rd_data[127:64], 64'hDEAD_BEEF);

        // 4. same-index write+alloc on 12
        set_rd(6'd12, 6'd9);
        wr_en = 1'b1; wr_addr = 6'd12; wr_data = 64'hAA;
        alloc_en = 1'b1; alloc_addr = 6'd12;
        #1;
        check("wa12_bypass_ready", rd_ready[0], 1'b1);
        step();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check("wa12_data", rd_data[63:0], 64'hAA);
        check("wa12_ready", rd_ready[0], 1'b0);
        check("wa12_all_ready", all_ready[12], 1'b0);

        // different indices: write 3, alloc 4
        wr_en = 1'b1; wr_addr = 6'd3; wr_data = 64'h33;
        alloc_en = 1'b1; alloc_addr = 6'd4;
        step();
        wr_en = 1'b0; alloc_en = 1'b0;
        set_rd(6'd3, 6'd4);
        #1;
        check("w3_data", rd_data[63:0], 64'h33);
        check("w3a4_ready", rd_ready, 2'b01);
        check("a4_all_ready", all_ready[4], 1'b0);
        set_rd(6'd3, 6'd3);
        #1;
        check("same_idx_data", rd_data, {64'h33, 64'h33});
        check("same_idx_ready", rd_ready, 2'b11);

        // 5. zero register
        set_rd(6'd63, 6'd63);
        wr_en = 1'b1; wr_addr = 6'd63; wr_data = 64'hFFFF;
        alloc_en = 1'b1; alloc_addr = 6'd63;
        #1;
        check("zero_same_data", rd_data, 128'h0);
        check("zero_same_ready", rd_ready, 2'b11);
        step();
        wr_en = 1'b0; alloc_en = 1'b0;
        #1;
        check("zero_after_data", rd_data, 128'h0);
        check("zero_after_ready", rd_ready, 2'b11);
        check("zero_all_ready", all_ready[63], 1'b1);

        // 6. write 1..4 then reset during a write to 7
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = 64'h11 * i;
            step();
        end
        wr_en = 1'b0;
        set_rd(6'd2, 6'd4);
        #1;
        check("pre_reset_data", rd_data, {64'h44, 64'h22});
        reset = 1'b1; wr_en = 1'b1; wr_addr = 6'd7; wr_data = 64'h77;
        alloc_en = 1'b1; alloc_addr = 6'd1;
        step();
        reset = 1'b0; wr_en = 1'b0; alloc_en = 1'b0;
        set_rd(6'd7, 6'd1);
        #1;
        check("post_reset_7_1", rd_data, 128'h0);
        check("post_reset_ready", rd_ready, 2'b11);
        set_rd(6'd2, 6'd4);
        #1;
        check("post_reset_2_4", rd_data, 128'h0);
        check("post_reset_all_ready", all_ready, {64{1'b1}});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
